// File: rtl/key_matrix_emu_if.sv
// rtl/key_matrix_emu_if.sv - press-command handshake and status bundle for key_matrix_emu
// Signals: i_cmd_valid/o_cmd_ready handshake; i_cmd_code, i_cmd_code2, i_hold_ms,
//          i_bounce_ms command fields; o_busy, o_done, o_cmd_err status.
// master = command source, slave = key_matrix_emu.
interface key_matrix_emu_if;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [4:0] i_cmd_code;
  logic [4:0] i_cmd_code2;
  logic [7:0] i_hold_ms;
  logic [3:0] i_bounce_ms;
  logic       o_busy;
  logic       o_done;
  logic       o_cmd_err;

  modport master (
    output i_cmd_valid, i_cmd_code, i_cmd_code2, i_hold_ms, i_bounce_ms,
    input  o_cmd_ready, o_busy, o_done, o_cmd_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_code, i_cmd_code2, i_hold_ms, i_bounce_ms,
    output o_cmd_ready, o_busy, o_done, o_cmd_err
  );
endinterface

// File: rtl/key_matrix_emu.sv
// rtl/key_matrix_emu.sv - emulates up to two pressed keys of a 4x5 matrix for a column scanner
// Ports: i_clk clock; i_rstn async active-low reset; i_pls_1k 1 ms tick;
//        i_key_out[3:0] active-low column strobes; o_key_in[4:0] active-low row returns;
//        cmd (slave) press-command handshake and busy/done/error status.
module key_matrix_emu (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_pls_1k,
  input  logic [3:0]      i_key_out,
  output logic [4:0]      o_key_in,
  key_matrix_emu_if.slave cmd
);
  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, RELEASE} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx, cnt_inc, limit;
  logic [4:0]  code1, code2;
  logic [7:0]  hold_ms;
  logic [3:0]  bounce_ms;
  logic        done_nx, err_nx, contact, accept, code_ok;
  logic [19:0] key_mask;
  logic [4:0]  key_in_nx;

  assign cmd.o_cmd_ready = (state == IDLE);
  assign cmd.o_busy      = (state != IDLE);
  assign accept          = cmd.i_cmd_valid && (state == IDLE);
  assign code_ok         = (cmd.i_cmd_code >= 5'd1) && (cmd.i_cmd_code <= 5'd20);
  assign cnt_inc         = cnt + 8'd1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    contact  = 1'b0;
    limit    = 8'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!code_ok) begin
            done_nx = 1'b1;
            err_nx  = 1'b1;
          end else begin
            state_nx = (cmd.i_bounce_ms != 4'd0) ? BOUNCE : HOLD;
          end
        end
      end
      BOUNCE: begin
        contact = cnt[0];
        limit   = {4'd0, bounce_ms};
      end
      HOLD: begin
        contact = 1'b1;
        limit   = (hold_ms == 8'd0) ? 8'd1 : hold_ms;
      end
      RELEASE: limit = 8'd2;
      default: state_nx = IDLE;
    endcase
    // The counter is zero whenever a state is entered, so a tick coinciding
    // with the entry edge is never counted.
    if ((state != IDLE) && i_pls_1k) begin
      if (cnt_inc == limit) begin
        cnt_nx = 8'd0;
        case (state)
          BOUNCE:  state_nx = HOLD;
          HOLD:    state_nx = RELEASE;
          default: begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        endcase
      end else begin
        cnt_nx = cnt_inc;
      end
    end
  end

  // One-hot of the latched keys; out-of-range codes simply never match.
  always_comb begin
    key_mask = '0;
    for (int k = 1; k <= 20; k++) begin
      if ((code1 == 5'(k)) || (code2 == 5'(k))) key_mask[5'(k - 1)] = 1'b1;
    end
    key_in_nx = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 5; r++) begin
        if (contact && key_mask[5'(c * 5 + r)] && !i_key_out[2'(c)]) key_in_nx[3'(r)] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      code1         <= 5'd0;
      code2         <= 5'd0;
      hold_ms       <= 8'd0;
      bounce_ms     <= 4'd0;
      o_key_in      <= 5'b11111;
      cmd.o_done    <= 1'b0;
      cmd.o_cmd_err <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      o_key_in      <= key_in_nx;
      cmd.o_done    <= done_nx;
      cmd.o_cmd_err <= err_nx;
      if (accept) begin
        code1     <= cmd.i_cmd_code;
        code2     <= (cmd.i_cmd_code2 <= 5'd20) ? cmd.i_cmd_code2 : 5'd0;
        hold_ms   <= cmd.i_hold_ms;
        bounce_ms <= cmd.i_bounce_ms;
      end
    end
  end
endmodule
